seed_serializer: RTL



---
 rtl/seed_serializer.sv | 76 +++++++
 1 files changed

// File: rtl/seed_serializer.sv
// seed_serializer: parallel WIDTH-bit word in, BEAT-bit beats out, MSB beat first.
// Ports: clk, reset (sync, active-high), seed/in_valid/in_ready (capture side),
//   out_data/out_valid/out_ready/out_last (beat side), busy, frames_sent (wrapping).
module seed_serializer #(
   parameter int WIDTH = 64,
   parameter int BEAT  = 8,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] seed,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [BEAT-1:0]  out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy,
   output logic [CNTW-1:0]  frames_sent
);

   localparam int NBEATS = WIDTH / BEAT;
   localparam int CW     = $clog2(NBEATS + 1);

   if (WIDTH % BEAT != 0) begin : g_bad_beat
      $error("seed_serializer: WIDTH must be a multiple of BEAT");
   end

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;

   // All outputs decode only from registered state.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == SEND);
   assign busy      = (state == SEND);
   assign out_data  = shreg[WIDTH-1 -: BEAT];
   assign out_last  = (state == SEND) && (cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         shreg       <= '0;
         cnt         <= '0;
         frames_sent <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg <= seed;
                  cnt   <= CW'(NBEATS);
                  state <= SEND;
               end
            end
            SEND: begin
               if (out_ready) begin
                  // Zero-fill keeps out_data at 0 once the frame drains.
                  shreg <= shreg << BEAT;
                  cnt   <= cnt - CW'(1);
                  if (cnt == CW'(1)) begin
                     state       <= IDLE;
                     frames_sent <= frames_sent + CNTW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
